// File: rtl/flex_edge_strobe.sv
// flex_edge_strobe
//   Multi-channel edge-to-pulse block with per-channel event divider.
//   Each channel synchronises a slow/asynchronous level input, detects the
//   edge(s) selected by its mode field, emits a one-cycle event pulse and
//   divides the event stream by a shared runtime ratio into a strobe.
//
// Ports
//   clk        in   clock, all logic on rising edge
//   n_rst      in   asynchronous reset, active-low
//   en_in      in   [NUM_CH]            level inputs, bit i = channel i
//   mode       in   [2*NUM_CH]          ch i in [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   div_val    in   [CNT_WIDTH]         shared divide ratio N (0 treated as 1)
//   clear      in   synchronous clear of counters and pulse outputs
//   edge_pulse out  [NUM_CH]            one-cycle pulse per detected edge
//   strobe_out out  [NUM_CH]            one-cycle pulse on every N-th event
//   count_out  out  [NUM_CH*CNT_WIDTH]  per-channel event count, ch0 in the LSBs
module flex_edge_strobe #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter bit          RESET_LEVEL = 1'b1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_CH-1:0]             en_in,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [CNT_WIDTH-1:0]          div_val,
    input  logic                          clear,
    output logic [NUM_CH-1:0]             edge_pulse,
    output logic [NUM_CH-1:0]             strobe_out,
    output logic [NUM_CH*CNT_WIDTH-1:0]   count_out
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    logic [NUM_CH-1:0] sync_s;

    // Synchroniser: SYNC_STAGES = 0 feeds the level input straight to the
    // edge detector.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_s = en_in;
        end else begin : g_sync
            logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
            logic [NUM_CH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = en_in;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= {NUM_CH{RESET_LEVEL}};
                    end
                end else begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [NUM_CH-1:0]                 prev_q, prev_d;
    logic [NUM_CH-1:0]                 pulse_q, pulse_d;
    logic [NUM_CH-1:0]                 strobe_q, strobe_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0]                 rise, fall, ev;
    logic [CNT_WIDTH-1:0]              eff, wrap_at;
    edge_mode_e                        ch_mode;

    always_comb begin
        eff     = (div_val == '0) ? CNT_WIDTH'(1) : div_val;
        wrap_at = eff - CNT_WIDTH'(1);

        // History tracks the synchronised level unconditionally so that
        // a clear or a mode change never manufactures a stale edge later.
        prev_d  = sync_s;
        rise    = sync_s & ~prev_q;
        fall    = ~sync_s & prev_q;

        ev      = '0;
        ch_mode = MODE_OFF;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_mode = edge_mode_e'(mode[2*i +: 2]);
            case (ch_mode)
                MODE_RISE: ev[i] = rise[i];
                MODE_FALL: ev[i] = fall[i];
                MODE_BOTH: ev[i] = rise[i] | fall[i];
                default:   ev[i] = 1'b0;
            endcase
        end

        pulse_d  = '0;
        strobe_d = '0;
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ev[i]) begin
                    pulse_d[i] = 1'b1;
                    // >= rather than == so a ratio lowered below the
                    // current count wraps on the next event.
                    if (cnt_q[i] >= wrap_at) begin
                        cnt_d[i]    = '0;
                        strobe_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q   <= {NUM_CH{RESET_LEVEL}};
            pulse_q  <= '0;
            strobe_q <= '0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign edge_pulse = pulse_q;
    assign strobe_out = strobe_q;
    assign count_out  = cnt_q;

endmodule

// File: tb/tb_flex_edge_strobe.sv
// tb_flex_edge_strobe
//   Directed bench for flex_edge_strobe (4 channels, 2 sync stages,
//   4-bit counters, reset level 1). A delay-line event model is checked
//   against the outputs on every falling clock edge, and directed steps
//   pin exact pulse timing, strobe positions, clear and reset behaviour.
module tb_flex_edge_strobe;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam bit RL   = 1'b1;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b0;
    logic [NCH-1:0]       en_in = '1;
    logic [2*NCH-1:0]     mode = 8'h55;
    logic [CW-1:0]        div_val = 4'd1;
    logic                 clear = 1'b0;
    logic [NCH-1:0]       edge_pulse;
    logic [NCH-1:0]       strobe_out;
    logic [NCH*CW-1:0]    count_out;

    int n_checks = 0;
    int n_fail   = 0;

    flex_edge_strobe #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SYNC),
        .CNT_WIDTH   (CW),
        .RESET_LEVEL (RL)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .en_in      (en_in),
        .mode       (mode),
        .div_val    (div_val),
        .clear      (clear),
        .edge_pulse (edge_pulse),
        .strobe_out (strobe_out),
        .count_out  (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level seen by the edge detector is the input as sampled SYNC edges ago.
    logic [NCH-1:0] m_dl [SYNC];
    logic [NCH-1:0] m_prev   = {NCH{RL}};
    logic [NCH-1:0] m_pulse  = '0;
    logic [NCH-1:0] m_strobe = '0;
    int             m_cnt [NCH];

    initial begin
        for (int j = 0; j < SYNC; j++) m_dl[j] = {NCH{RL}};
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end

    always @(posedge clk or negedge n_rst) begin : model
        logic [NCH-1:0] s;
        logic [1:0]     md;
        logic           r, f, ev;
        int             eff;
        if (!n_rst) begin
            for (int j = 0; j < SYNC; j++) m_dl[j] = {NCH{RL}};
            m_prev   = {NCH{RL}};
            m_pulse  = '0;
            m_strobe = '0;
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        end else begin
            s = m_dl[SYNC-1];
            for (int j = SYNC-1; j > 0; j--) m_dl[j] = m_dl[j-1];
            m_dl[0] = en_in;
            eff = (div_val == 0) ? 1 : int'(div_val);
            for (int c = 0; c < NCH; c++) begin
                md = mode[2*c +: 2];
                r  = s[c] & ~m_prev[c];
                f  = ~s[c] & m_prev[c];
                ev = (md[0] & r) | (md[1] & f);
                m_pulse[c]  = 1'b0;
                m_strobe[c] = 1'b0;
                if (clear) begin
                    m_cnt[c] = 0;
                end else if (ev) begin
                    m_pulse[c] = 1'b1;
                    m_cnt[c]   = m_cnt[c] + 1;
                    if (m_cnt[c] >= eff) begin
                        m_cnt[c]    = 0;
                        m_strobe[c] = 1'b1;
                    end
                end
            end
            m_prev = s;
        end
    end

    function automatic logic [NCH*CW-1:0] model_counts();
        logic [NCH*CW-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[CW*c +: CW] = CW'(m_cnt[c]);
        return v;
    endfunction

    always @(negedge clk) begin
        check("cyc_edge_pulse", 32'(edge_pulse), 32'(m_pulse));
        check("cyc_strobe_out", 32'(strobe_out), 32'(m_strobe));
        check("cyc_count_out",  32'(count_out),  32'(model_counts()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return count_out[CW*c +: CW];
    endfunction

    task automatic ch0_event();
        en_in[0] = 1'b1;
        tick(3);
        check("ch0_evt_pulse", 32'(edge_pulse[0]), 32'd1);
        en_in[0] = 1'b0;
        tick(2);
    endtask

    int pc [NCH];
    int sc [NCH];

    initial begin
        // Reset with all inputs high, rise mode on every channel.
        #12;
        check("rst_pulse",  32'(edge_pulse), 32'd0);
        check("rst_strobe", 32'(strobe_out), 32'd0);
        check("rst_count",  32'(count_out),  32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("rel_high_no_pulse", 32'(edge_pulse), 32'd0);
        end

        // Falling edges with fall mode: exactly one pulse per channel.
        en_in = '0;
        mode  = 8'hAA;
        for (int c = 0; c < NCH; c++) begin pc[c] = 0; sc[c] = 0; end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            for (int c = 0; c < NCH; c++) begin
                pc[c] += int'(edge_pulse[c]);
                sc[c] += int'(strobe_out[c]);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            check("fall_pulse_count",  32'(pc[c]), 32'd1);
            check("fall_strobe_count", 32'(sc[c]), 32'd1);
        end

        // Exact latency on ch0, div 1.
        mode    = 8'h01;
        div_val = 4'd1;
        tick(3);
        en_in[0] = 1'b1;
        tick(1);
        check("lat_k",   32'(edge_pulse[0]), 32'd0);
        tick(1);
        check("lat_k1",  32'(edge_pulse[0]), 32'd0);
        tick(1);
        check("lat_k2_pulse",  32'(edge_pulse[0]), 32'd1);
        check("lat_k2_strobe", 32'(strobe_out[0]), 32'd1);
        tick(1);
        check("lat_k3",  32'(edge_pulse[0]), 32'd0);

        // ch1 rise, div 8, 16 rising edges.
        mode    = 8'h04;
        div_val = 4'd8;
        clear   = 1'b1;
        tick(1);
        clear   = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            en_in[1] = 1'b1;
            tick(3);
            check("div8_pulse",  32'(edge_pulse[1]), 32'd1);
            check("div8_strobe", 32'(strobe_out[1]), 32'((e % 8) == 0));
            check("div8_count",  32'(cnt_of(1)), 32'(e % 8));
            en_in[1] = 1'b0;
            tick(2);
        end

        // ch2 both edges, div 3, then mode off.
        mode    = 8'h30;
        div_val = 4'd3;
        clear   = 1'b1;
        tick(1);
        clear   = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            en_in[2] = ~en_in[2];
            tick(3);
            check("both_pulse",  32'(edge_pulse[2]), 32'd1);
            check("both_strobe", 32'(strobe_out[2]), 32'((t % 3) == 0));
            check("both_count",  32'(cnt_of(2)), 32'(t % 3));
        end
        mode = 8'h00;
        for (int t = 0; t < 2; t++) begin
            en_in[2] = ~en_in[2];
            tick(3);
            check("off_pulse", 32'(edge_pulse[2]), 32'd0);
            check("off_count", 32'(cnt_of(2)), 32'd1);
        end

        // Clear coincident with a ch0 event, then lowering the ratio.
        mode    = 8'h01;
        div_val = 4'd8;
        en_in[0] = 1'b0;
        clear   = 1'b1;
        tick(1);
        clear   = 1'b0;
        tick(3);
        ch0_event();
        ch0_event();
        check("pre_clear_count", 32'(cnt_of(0)), 32'd2);
        en_in[0] = 1'b1;
        tick(2);
        clear = 1'b1;
        tick(1);
        check("clr_pulse", 32'(edge_pulse[0]), 32'd0);
        check("clr_count", 32'(cnt_of(0)), 32'd0);
        clear = 1'b0;
        tick(2);
        check("post_clr_pulse", 32'(edge_pulse[0]), 32'd0);
        en_in[0] = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) ch0_event();
        check("cnt5", 32'(cnt_of(0)), 32'd5);
        div_val  = 4'd2;
        en_in[0] = 1'b1;
        tick(3);
        check("lower_div_strobe", 32'(strobe_out[0]), 32'd1);
        check("lower_div_count",  32'(cnt_of(0)), 32'd0);
        en_in[0] = 1'b0;
        tick(2);

        // Asynchronous reset mid-count.
        en_in[0] = 1'b1;
        tick(3);
        check("pre_rst_count", 32'(cnt_of(0)), 32'd1);
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        check("async_rst_pulse",  32'(edge_pulse), 32'd0);
        check("async_rst_strobe", 32'(strobe_out), 32'd0);
        check("async_rst_count",  32'(count_out),  32'd0);
        #3 n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("post_rst_no_pulse", 32'(edge_pulse), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
